// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CHECK,
        BACKOFF
    } arb_state_e;

    localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner,
    output logic             any_grant
);

    logic [31:0]      idx;
    logic [PTR_W-1:0] idx_p;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = '0;
        idx_p     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx   = (32'(ptr) + i) % N_REQ;
            idx_p = PTR_W'(idx);
            if (!any_grant && req[idx_p]) begin
                any_grant    = 1'b1;
                grant[idx_p] = 1'b1;
                winner       = idx_p;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; holds each word until acked, replays on overflow.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned MAX_RETRY  = 3,
    localparam int unsigned PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [PTR_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        err_drop,
    output logic [DROP_CNT_W-1:0]       drop_count
);

    arb_state_e             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [RETRY_W-1:0]     retry_cnt;
    logic [FIFO_WIDTH-1:0]  hold_data;

    logic [N_REQ-1:0]       arb_grant;
    logic [PTR_W-1:0]       arb_winner;
    logic                   arb_any;
    logic                   grant_window;
    logic                   grant_fire;
    logic                   ovf_like;
    logic [PTR_W-1:0]       next_ptr;
    logic [FIFO_WIDTH-1:0]  win_data;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .winner    (arb_winner),
        .any_grant (arb_any)
    );

    assign grant_window = (state == IDLE) || ((state == CHECK) && fifo_wr_ack);
    // Gated with rst so req_ready is low throughout reset, not only after it.
    assign grant_fire   = grant_window && arb_any && !fifo_full && !rst;
    assign req_ready    = grant_fire ? arb_grant : '0;
    // A missing ack with no overflow is a protocol error and is retried like an overflow.
    assign ovf_like     = fifo_overflow || !fifo_wr_ack;
    assign next_ptr     = (arb_winner == PTR_W'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign fifo_wr_en   = (state == WRITE);
    assign fifo_data_in = hold_data;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            retry_cnt  <= '0;
            hold_data  <= '0;
            grant_id   <= '0;
            err_drop   <= 1'b0;
            drop_count <= '0;
        end else begin
            err_drop <= 1'b0;
            if (grant_fire) begin
                hold_data <= win_data;
                grant_id  <= arb_winner;
                rr_ptr    <= next_ptr;
                retry_cnt <= '0;
                state     <= WRITE;
            end else begin
                case (state)
                    IDLE:    state <= IDLE;
                    WRITE:   state <= CHECK;
                    CHECK: begin
                        if (fifo_wr_ack) begin
                            state <= IDLE;
                        end else if (ovf_like) begin
                            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= BACKOFF;
                            end else begin
                                err_drop <= 1'b1;
                                if (drop_count != '1) drop_count <= drop_count + 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    BACKOFF: if (!fifo_full) state <= WRITE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a registered-response FIFO model.
module tb_fifo_wr_arbiter;

    localparam int N_REQ      = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int MAX_RETRY  = 3;
    localparam int NVEC       = 15;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [N_REQ-1:0]            req_valid = '0;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data = '0;
    logic [N_REQ-1:0]            req_ready;
    logic [FIFO_WIDTH-1:0]       fifo_data_in;
    logic                        fifo_wr_en;
    logic                        fifo_full = 1'b0;
    logic                        fifo_wr_ack = 1'b0;
    logic                        fifo_overflow = 1'b0;
    logic [1:0]                  grant_id;
    logic                        busy;
    logic                        err_drop;
    logic [7:0]                  drop_count;

    typedef struct {
        logic [N_REQ-1:0] valid;
        int               winner;
    } vec_t;

    vec_t            vecs[NVEC];
    logic [15:0]     exp_q[$];
    int              checks   = 0;
    int              failures = 0;
    bit              sb_en    = 1'b1;
    int              wr_count = 0;
    int              ovf_lo   = 0;
    int              ovf_hi   = 0;

    fifo_wr_arbiter #(
        .N_REQ      (N_REQ),
        .FIFO_WIDTH (FIFO_WIDTH),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_data_in  (fifo_data_in),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_drop      (err_drop),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] lane(int i);
        return 16'(16'h1111 * (i + 1));
    endfunction

    // FIFO model: response one cycle after wr_en; writes numbered [ovf_lo, ovf_hi) overflow.
    always @(posedge clk) begin
        if (fifo_wr_en) begin
            fifo_overflow <= (wr_count >= ovf_lo) && (wr_count < ovf_hi);
            fifo_wr_ack   <= !((wr_count >= ovf_lo) && (wr_count < ovf_hi));
            wr_count      <= wr_count + 1;
        end else begin
            fifo_overflow <= 1'b0;
            fifo_wr_ack   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            chk("ready_in_write", 32'(req_ready), 32'd0);
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_wr: got data %0h expected no write",
                             fifo_data_in);
                end else begin
                    chk("sb_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        ovf_lo    = 0;
        ovf_hi    = 0;
        repeat (2) nxt();
        rst = 1'b0;
    endtask

    initial begin
        int err_n;

        for (int i = 0; i < N_REQ; i++) req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = lane(i);

        for (int k = 0; k < 8; k++) vecs[k] = '{4'b1111, k % 4};
        vecs[8]  = '{4'b1010, 1};
        vecs[9]  = '{4'b1010, 3};
        vecs[10] = '{4'b0101, 0};
        vecs[11] = '{4'b0101, 2};
        vecs[12] = '{4'b0001, 0};
        vecs[13] = '{4'b1000, 3};
        vecs[14] = '{4'b0110, 1};

        // Reset state.
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wren", 32'(fifo_wr_en), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_err", 32'(err_drop), 0);
        chk("rst_dcnt", 32'(drop_count), 0);
        chk("rst_data", 32'(fifo_data_in), 0);
        do_reset();

        // Single requester latency.
        req_valid = 4'b0001;
        smp();
        chk("t1_ready_c0", 32'(req_ready), 32'b0001);
        exp_q.push_back(lane(0));
        nxt();
        req_valid = '0;
        smp();
        chk("t1_wren_c1", 32'(fifo_wr_en), 1);
        nxt();
        smp();
        chk("t1_ack_c2", 32'(fifo_wr_ack), 1);
        chk("t1_busy_c2", 32'(busy), 1);
        nxt();
        smp();
        chk("t1_busy_c3", 32'(busy), 0);

        // Fairness and rotation table, one word per two cycles.
        do_reset();
        for (int k = 0; k < NVEC; k++) begin
            req_valid = vecs[k].valid;
            smp();
            chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(1 << vecs[k].winner));
            exp_q.push_back(lane(vecs[k].winner));
            nxt();
            smp();
            chk($sformatf("vec%0d_wren", k), 32'(fifo_wr_en), 1);
            chk($sformatf("vec%0d_gid", k), 32'(grant_id), 32'(vecs[k].winner));
            nxt();
        end
        req_valid = '0;
        repeat (2) nxt();
        smp();
        chk("table_idle", 32'(busy), 0);

        // Full stall in IDLE.
        do_reset();
        fifo_full = 1'b1;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("full_ready", 32'(req_ready), 0);
            chk("full_wren", 32'(fifo_wr_en), 0);
            nxt();
        end
        fifo_full = 1'b0;
        smp();
        chk("full_release_ready", 32'(req_ready), 32'b0100);
        exp_q.push_back(lane(2));
        nxt();
        req_valid = '0;
        smp();
        chk("full_release_wren", 32'(fifo_wr_en), 1);
        repeat (2) nxt();

        // Two overflows then ack: same word written three times, no drop.
        do_reset();
        ovf_lo    = wr_count;
        ovf_hi    = wr_count + 2;
        req_valid = 4'b0001;
        smp();
        chk("retry_ready", 32'(req_ready), 32'b0001);
        repeat (3) exp_q.push_back(lane(0));
        nxt();
        req_valid = '0;
        err_n = 0;
        for (int c = 0; c < 40; c++) begin
            smp();
            if (err_drop) err_n++;
            if (!busy) break;
            nxt();
        end
        chk("retry_idle", 32'(busy), 0);
        chk("retry_no_drop", 32'(err_n), 0);
        chk("retry_dcnt", 32'(drop_count), 0);
        chk("retry_sb_empty", 32'(exp_q.size()), 0);

        // Overflow on every write: four writes, then drop, then next requester.
        do_reset();
        ovf_lo    = wr_count;
        ovf_hi    = wr_count + 4;
        req_valid = 4'b0011;
        smp();
        chk("drop_ready", 32'(req_ready), 32'b0001);
        repeat (4) exp_q.push_back(lane(0));
        nxt();
        req_valid = 4'b0010;
        for (int c = 0; c < 60; c++) begin
            smp();
            if (err_drop) break;
            nxt();
        end
        chk("drop_pulse", 32'(err_drop), 1);
        chk("drop_dcnt", 32'(drop_count), 1);
        chk("drop_idle", 32'(busy), 0);
        chk("drop_sb_empty", 32'(exp_q.size()), 0);
        chk("drop_next_grant", 32'(req_ready), 32'b0010);
        exp_q.push_back(lane(1));
        nxt();
        req_valid = '0;
        smp();
        chk("drop_pulse_once", 32'(err_drop), 0);
        chk("drop_next_wren", 32'(fifo_wr_en), 1);
        repeat (3) nxt();

        // Reset during CHECK.
        do_reset();
        req_valid = 4'b0100;
        smp();
        chk("rmid_ready", 32'(req_ready), 32'b0100);
        exp_q.push_back(lane(2));
        nxt();
        req_valid = '0;
        nxt();
        req_valid = 4'b1010;
        #1;
        rst = 1'b1;
        #1;
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_wren", 32'(fifo_wr_en), 0);
        chk("rmid_ready_low", 32'(req_ready), 0);
        chk("rmid_gid", 32'(grant_id), 0);
        nxt();
        rst = 1'b0;
        smp();
        chk("rmid_first_grant", 32'(req_ready), 32'b0010);
        exp_q.push_back(lane(1));
        nxt();
        req_valid = '0;
        smp();
        chk("rmid_wren_after", 32'(fifo_wr_en), 1);
        repeat (2) nxt();

        // Drop counter saturation.
        do_reset();
        sb_en = 1'b0;
        exp_q.delete();
        ovf_lo    = 0;
        ovf_hi    = 32'h7fff_ffff;
        req_valid = 4'b0001;
        for (int c = 0; c < 4000; c++) begin
            smp();
            if (drop_count == 8'hFF) break;
            nxt();
        end
        chk("sat_reach", 32'(drop_count), 255);
        err_n = 0;
        for (int c = 0; c < 30; c++) begin
            nxt();
            smp();
            if (err_drop) err_n++;
        end
        chk("sat_hold", 32'(drop_count), 255);
        chk("sat_still_dropping", 32'(err_n > 0), 1);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous FIFO between N_REQ producers using round-robin arbitration.
- Holds each granted word until the FIFO acknowledges it with wr_ack.
- Replays the word on overflow, up to MAX_RETRY times, then drops it and flags the drop.
- Sits between the producer blocks and the FIFO write-side pins (data_in, wr_en, full, wr_ack, overflow).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data word width.
- MAX_RETRY, 3, overflow replays allowed before a word is dropped.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a word.
- req_data  in  N_REQ x FIFO_WIDTH  word per requester.
- req_ready  out  N_REQ  one-hot accept pulse; word captured at this edge.
- fifo_data_in  out  FIFO_WIDTH  to FIFO data_in.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_full  in  1  from FIFO full.
- fifo_wr_ack  in  1  from FIFO wr_ack (registered, one cycle after wr_en).
- fifo_overflow  in  1  from FIFO overflow (registered, one cycle after wr_en).
- grant_id  out  $clog2(N_REQ)  owner of the held word.
- busy  out  1  held word outstanding (state != IDLE).
- err_drop  out  1  one-cycle pulse when a word is dropped.
- drop_count  out  8  saturating count of dropped words.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, all outputs 0, rr pointer=0, retry_cnt=0, drop_count=0.
  - A transaction in flight is abandoned: no ready, no drop flagged.
- States: IDLE, WRITE, CHECK, BACKOFF.
- Grant condition: evaluated in IDLE, and in CHECK when fifo_wr_ack=1.
  - Requires |req_valid && !fifo_full.
  - Winner = first asserted req_valid at or after rr pointer, wrapping N_REQ-1 -> 0.
  - req_ready[winner]=1 combinationally that cycle. At the edge: hold_data<=req_data[winner], grant_id<=winner, rr pointer<=(winner+1) mod N_REQ, retry_cnt<=0, next state WRITE.
  - If no grant: IDLE stays IDLE; CHECK with ack goes to IDLE.
- WRITE: fifo_wr_en=1, fifo_data_in=hold_data for exactly one cycle, then CHECK.
- CHECK (fifo_wr_en=0), by response:
  - fifo_wr_ack=1: word done; grant condition re-evaluated, giving back-to-back throughput of one word per 2 cycles.
  - fifo_overflow=1, or neither flag (protocol error, treated as overflow):
    - retry_cnt<MAX_RETRY: retry_cnt++, go BACKOFF.
    - otherwise: err_drop pulse, drop_count++ (saturate at 255), go IDLE.
  - Both flags at once: wr_ack wins.
- BACKOFF: wait while fifo_full=1; when fifo_full=0, go WRITE, replaying the same hold_data.
- Latency: req_ready to fifo_wr_en = 1 cycle. Word accepted to ack visible = 2 cycles.
- Requester rules:
  - Only one req_ready bit is high per cycle.
  - req_ready is never high in WRITE or BACKOFF.
  - req_data must be stable while req_valid is high and not yet accepted.
  - Deasserting req_valid before acceptance is legal; that requester loses its turn.
- fifo_full=1 in IDLE: no grant, no wr_en.
- N_REQ=1: pointer fixed at 0.

Decomposition:
- Shared package fifo_arb_pkg:
  - arb_state_e enum {IDLE, WRITE, CHECK, BACKOFF}.
  - DROP_CNT_W=8 constant.
- One sub-module, rr_arbiter (parameter N_REQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded winner, any_grant. Purely combinational.
- Pointer register and FSM live in fifo_wr_arbiter.

Test Plan:
- Single requester: req_valid=4'b0001, data 16'hA5A5, FIFO empty -> req_ready[0] cycle 0; wr_en with 16'hA5A5 cycle 1; ack cycle 2; busy deasserts cycle 3.
- Fairness: all four valid continuously for 8 words, pointer=0 -> grant order 0,1,2,3,0,1,2,3; one word per 2 cycles; no req_ready in WRITE cycles.
- Full stall: fifo_full=1 with req_valid=4'b0100 -> no req_ready and no wr_en until fifo_full drops; then grant 2 next cycle.
- Overflow retry: first two writes answered with overflow, third with wr_ack -> same data written 3 times, err_drop=0, drop_count=0.
- Drop: MAX_RETRY=3, overflow on every write -> 4 wr_en pulses, then err_drop pulse, drop_count=1, state IDLE, next requester granted.
- Reset mid-op: assert rst during CHECK -> outputs 0 asynchronously; after release, pointer=0 and first grant goes to lowest valid index.
